// File: rtl/vertexinput_fetch_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vertexinput_fetch_ctrl_if
// Brief    : Read-port (req/ack) and vertex output stream (valid/ready) bundle
//            for the vertex-input fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
interface vertexinput_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic [DATA_W-1:0] rd_data;

    logic              m_vtx_valid;
    logic [DATA_W-1:0] m_vtx_data;
    logic              m_vtx_last;
    logic              m_vtx_ready;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_data,
        output m_vtx_valid,
        output m_vtx_data,
        output m_vtx_last,
        input  m_vtx_ready
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_data,
        input  m_vtx_valid,
        input  m_vtx_data,
        input  m_vtx_last,
        output m_vtx_ready
    );
endinterface
`default_nettype wire

// File: rtl/vertexinput_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vertexinput_fetch_ctrl
// Brief    : Fetches a run of vertex words over a single-outstanding req/ack
//            port into a small FWFT FIFO and streams them out with a last flag.
// Revision : 1.0 - initial release
// ============================================================================
module vertexinput_fetch_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [CNT_W-1:0]  cfg_vtx_count,
    input  logic [7:0]        cfg_stride,
    input  logic              start_pulse,
    input  logic              abort_pulse,
    output logic              status_busy,
    output logic              status_done,
    output logic [1:0]        irq_flags,
    input  logic [1:0]        irq_clr,
    vertexinput_fetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_ABORT = 2'd3;

    localparam logic [PTR_W:0]   c_DEPTH   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   c_OCC_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_idx;
    logic [7:0]        r_stride;
    logic              r_req;
    logic              r_busy;
    logic              r_done;
    logic [1:0]        r_irq;

    logic [DATA_W-1:0] r_mem      [FIFO_DEPTH];
    logic              r_mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_occ;

    logic w_valid;
    logic w_pop;
    logic w_ack;
    logic w_push;
    logic w_abort;
    logic w_start_ok;
    logic w_start_zero;
    logic w_last_idx;
    logic w_issue;
    logic w_done_evt;

    assign w_valid      = (r_occ != '0);
    assign w_pop        = w_valid & bus.m_vtx_ready;
    assign w_ack        = r_req & bus.rd_ack;
    assign w_push       = w_ack & (r_state == c_FETCH);
    assign w_abort      = abort_pulse & ((r_state == c_FETCH) | (r_state == c_DRAIN));
    assign w_start_ok   = start_pulse & (r_state == c_IDLE) & (cfg_vtx_count != '0);
    assign w_start_zero = start_pulse & (r_state == c_IDLE) & (cfg_vtx_count == '0);
    assign w_last_idx   = (r_idx == (r_count - c_CNT_ONE));
    // A new request only goes out once the previous one has dropped, and only
    // when the FIFO can hold the word it will return.
    assign w_issue      = (r_state == c_FETCH) & ~r_req & ~w_abort & (r_occ < c_DEPTH);
    assign w_done_evt   = (r_state == c_DRAIN) & ~w_abort & (r_occ == '0);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_start_ok) w_state_nxt = c_FETCH;
            c_FETCH: begin
                if (w_abort)                  w_state_nxt = c_ABORT;
                else if (w_push & w_last_idx) w_state_nxt = c_DRAIN;
            end
            c_DRAIN: begin
                if (w_abort)         w_state_nxt = c_ABORT;
                else if (w_done_evt) w_state_nxt = c_IDLE;
            end
            c_ABORT: if (~r_req | bus.rd_ack) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= c_IDLE;
            r_busy   <= 1'b0;
            r_addr   <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_stride <= '0;
            r_req    <= 1'b0;
            r_done   <= 1'b0;
            r_irq    <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != c_IDLE);
            if (w_start_ok) begin
                r_addr   <= cfg_base_addr;
                r_count  <= cfg_vtx_count;
                r_stride <= cfg_stride;
                r_idx    <= '0;
                r_req    <= 1'b1;
                r_done   <= 1'b0;
            end else begin
                if (w_ack)        r_req <= 1'b0;
                else if (w_issue) r_req <= 1'b1;
                if (w_push) begin
                    r_idx  <= r_idx + c_CNT_ONE;
                    r_addr <= r_addr + ADDR_W'(r_stride);
                end
                if (w_done_evt) r_done <= 1'b1;
            end
            // Set wins over a coincident clear.
            r_irq <= (r_irq & ~irq_clr) | {w_start_zero, w_done_evt};
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i]      <= '0;
                r_mem_last[i] <= 1'b0;
            end
        end else if (w_abort) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr]      <= bus.rd_data;
                r_mem_last[r_wptr] <= w_last_idx;
                r_wptr             <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + c_OCC_ONE;
                2'b01:   r_occ <= r_occ - c_OCC_ONE;
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign bus.rd_req      = r_req;
    assign bus.rd_addr     = r_addr;
    assign bus.m_vtx_valid = w_valid;
    assign bus.m_vtx_data  = w_valid ? r_mem[r_rptr] : '0;
    assign bus.m_vtx_last  = w_valid & r_mem_last[r_rptr];
    assign status_busy     = r_busy;
    assign status_done     = r_done;
    assign irq_flags       = r_irq;
endmodule
`default_nettype wire

// File: tb/tb_vertexinput_fetch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vertexinput_fetch_ctrl
// Brief    : Self-checking bench: table of runs plus hand-written corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vertexinput_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cfg_base;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_stride;
    logic        start_pulse;
    logic        abort_pulse;
    logic [1:0]  irq_clr;
    logic        busy;
    logic        done;
    logic [1:0]  irq;

    always #5 clk = ~clk;

    vertexinput_fetch_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    vertexinput_fetch_ctrl #(
        .ADDR_W(32), .DATA_W(32), .CNT_W(16), .FIFO_DEPTH(4)
    ) dut (
        .aclk          (clk),
        .aresetn       (rst_n),
        .cfg_base_addr (cfg_base),
        .cfg_vtx_count (cfg_count),
        .cfg_stride    (cfg_stride),
        .start_pulse   (start_pulse),
        .abort_pulse   (abort_pulse),
        .status_busy   (busy),
        .status_done   (done),
        .irq_flags     (irq),
        .irq_clr       (irq_clr),
        .bus           (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } out_t;

    typedef struct {
        logic [31:0] base;
        logic [15:0] count;
        logic [7:0]  stride;
        int          rdy;
        int          lat;
        logic [31:0] exp_last_addr;
        logic [1:0]  exp_irq;
        logic        exp_done;
    } vec_t;

    out_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_acks = 0;
    int          ack_lat = 1;
    int          ready_pct = 100;
    logic [31:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] vdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Read-port responder: checks each address against the model queue.
    logic [31:0] resp_addr;
    logic        resp_dead;
    int          resp_lat;
    initial begin
        bus.rd_ack  = 1'b0;
        bus.rd_data = '0;
        forever begin
            @(negedge clk);
            bus.rd_ack = 1'b0;
            if (rst_n && bus.rd_req) begin
                resp_dead = 1'b0;
                resp_lat  = ack_lat;
                if (addr_q.size() == 0) begin
                    resp_addr = bus.rd_addr;
                    fail_now($sformatf("unexpected_read addr %0h", bus.rd_addr));
                end else begin
                    resp_addr = addr_q.pop_front();
                    check("rd_addr", bus.rd_addr, resp_addr);
                end
                last_addr = bus.rd_addr;
                for (int k = 1; k < resp_lat; k++) begin
                    @(negedge clk);
                    if (!rst_n) resp_dead = 1'b1;
                    else if (!resp_dead)
                        check("rd_req_hold", {bus.rd_req, bus.rd_addr}, {1'b1, resp_addr});
                end
                if (!resp_dead && rst_n) begin
                    bus.rd_ack  = 1'b1;
                    bus.rd_data = vdata(resp_addr);
                    n_acks++;
                    @(negedge clk);
                    bus.rd_ack = 1'b0;
                end
            end
        end
    end

    // Output monitor: drives ready, pops the scoreboard on each handshake.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;
    out_t        mon_e;
    initial begin
        bus.m_vtx_ready = 1'b0;
        forever begin
            @(negedge clk);
            bus.m_vtx_ready = (int'($urandom_range(99)) < ready_pct);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && bus.m_vtx_valid)
                    check("hold_stable", {bus.m_vtx_last, bus.m_vtx_data}, {prev_last, prev_data});
                if (bus.m_vtx_valid && bus.m_vtx_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now($sformatf("unexpected_output data %0h", bus.m_vtx_data));
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("out_word", {bus.m_vtx_last, bus.m_vtx_data}, {mon_e.last, mon_e.data});
                    end
                end
                prev_stall = bus.m_vtx_valid && !bus.m_vtx_ready;
                prev_data  = bus.m_vtx_data;
                prev_last  = bus.m_vtx_last;
            end
        end
    end

    task automatic start_run(input logic [31:0] b, input logic [15:0] c, input logic [7:0] s);
        for (int i = 0; i < int'(c); i++) begin
            logic [31:0] a;
            out_t        o;
            a      = b + 32'(i) * 32'(s);
            o.data = vdata(a);
            o.last = (i == int'(c) - 1);
            addr_q.push_back(a);
            exp_q.push_back(o);
        end
        cfg_base    = b;
        cfg_count   = c;
        cfg_stride  = s;
        start_pulse = 1'b1;
        tick(1);
        start_pulse = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while (busy && k < max) begin
            tick(1);
            k++;
        end
        if (busy) fail_now({name, "_idle_timeout"});
    endtask

    task automatic wait_acks(input string name, input int target, input int max);
        int k = 0;
        while (n_acks < target && k < max) begin
            tick(1);
            k++;
        end
        if (n_acks < target) fail_now({name, "_ack_timeout"});
    endtask

    task automatic wait_req(input string name, input logic lvl, input int max);
        int k = 0;
        while (bus.rd_req !== lvl && k < max) begin
            tick(1);
            k++;
        end
        if (bus.rd_req !== lvl) fail_now({name, "_req_timeout"});
    endtask

    task automatic clear_irq();
        irq_clr = 2'b11;
        tick(1);
        irq_clr = 2'b00;
    endtask

    vec_t vecs[4];
    int   acks0;

    initial begin
        cfg_base = '0; cfg_count = '0; cfg_stride = '0;
        start_pulse = 1'b0; abort_pulse = 1'b0; irq_clr = 2'b00;
        vecs[0] = '{32'h0000_1000, 16'd3, 8'd16, 100, 1, 32'h0000_1020, 2'b01, 1'b1};
        vecs[1] = '{32'hFFFF_FFF8, 16'd3, 8'd8,  100, 1, 32'h0000_0008, 2'b01, 1'b1};
        vecs[2] = '{32'h0000_2000, 16'd8, 8'd4,  50,  2, 32'h0000_201C, 2'b01, 1'b1};
        vecs[3] = '{32'h0000_3000, 16'd0, 8'd4,  100, 1, 32'h0000_0000, 2'b10, 1'b1};
        tick(3);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_irq",   irq, 0);
        check("rst_req",   bus.rd_req, 0);
        check("rst_addr",  bus.rd_addr, 0);
        check("rst_valid", bus.m_vtx_valid, 0);
        check("rst_data",  bus.m_vtx_data, 0);
        check("rst_last",  bus.m_vtx_last, 0);
        rst_n = 1'b1;
        tick(2);

        for (int v = 0; v < 4; v++) begin
            clear_irq();
            check("irq_cleared", irq, 0);
            ready_pct = vecs[v].rdy;
            ack_lat   = vecs[v].lat;
            start_run(vecs[v].base, vecs[v].count, vecs[v].stride);
            tick(2);
            wait_idle("run", 1000);
            check("run_irq",    irq, vecs[v].exp_irq);
            check("run_done",   done, vecs[v].exp_done);
            check("reads_left", addr_q.size(), 0);
            check("words_left", exp_q.size(), 0);
            if (vecs[v].count != 0) check("last_addr", last_addr, vecs[v].exp_last_addr);
        end

        // Zero-count flag: clear alone, then clear coinciding with a new set.
        irq_clr = 2'b10;
        tick(1);
        irq_clr = 2'b00;
        check("zc_clear", irq, 2'b00);
        cfg_count = '0; start_pulse = 1'b1; irq_clr = 2'b10;
        tick(1);
        start_pulse = 1'b0; irq_clr = 2'b00;
        check("zc_set_wins", irq, 2'b10);
        tick(1);
        check("zc_busy", busy, 0);

        // Backpressure: FIFO fills, fetching stalls, then drains in order.
        clear_irq();
        ready_pct = 0; ack_lat = 1; acks0 = n_acks;
        start_run(32'h0000_5000, 16'd8, 8'd4);
        tick(40);
        check("bp_acks",  n_acks - acks0, 4);
        check("bp_req",   bus.rd_req, 0);
        check("bp_valid", bus.m_vtx_valid, 1);
        ready_pct = 100;
        wait_idle("bp", 500);
        check("bp_words_left", exp_q.size(), 0);
        check("bp_irq", irq, 2'b01);

        // Abort with a slow read outstanding.
        clear_irq();
        ready_pct = 0; ack_lat = 1; acks0 = n_acks;
        start_run(32'h0000_6000, 16'd4, 8'd4);
        wait_acks("ab", acks0 + 2, 50);
        ack_lat = 5;
        wait_req("ab_lo", 1'b0, 10);
        wait_req("ab_hi", 1'b1, 10);
        check("ab_pre_valid", bus.m_vtx_valid, 1);
        abort_pulse = 1'b1;
        tick(1);
        abort_pulse = 1'b0;
        check("ab_req_held", bus.rd_req, 1);
        tick(1);
        check("ab_flush", bus.m_vtx_valid, 0);
        wait_idle("ab", 50);
        check("ab_acks", n_acks - acks0, 3);
        check("ab_irq",  irq, 2'b00);
        check("ab_done", done, 0);
        ready_pct = 100;
        tick(5);
        check("ab_no_output", exp_q.size(), 4);
        check("ab_reads_left", addr_q.size(), 1);
        exp_q.delete();
        addr_q.delete();

        ack_lat = 2;
        start_run(32'h0000_1000, 16'd3, 8'd16);
        tick(2);
        wait_idle("post_ab", 200);
        check("post_ab_irq",  irq, 2'b01);
        check("post_ab_done", done, 1);
        check("post_ab_words_left", exp_q.size(), 0);
        check("post_ab_last_addr", last_addr, 32'h0000_1020);

        // Start while busy is ignored; then asynchronous reset mid-fetch.
        clear_irq();
        ready_pct = 0; ack_lat = 3; acks0 = n_acks;
        start_run(32'h0000_4000, 16'd6, 8'd4);
        wait_acks("sb", acks0 + 2, 100);
        cfg_base = 32'h0000_9000; cfg_count = 16'd2; cfg_stride = 8'h40;
        start_pulse = 1'b1;
        tick(1);
        start_pulse = 1'b0;
        wait_acks("sb2", acks0 + 3, 100);
        wait_req("sb_lo", 1'b0, 10);
        wait_req("sb_hi", 1'b1, 10);
        check("pre_rst_busy",  busy, 1);
        check("pre_rst_valid", bus.m_vtx_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req",   bus.rd_req, 0);
        check("arst_valid", bus.m_vtx_valid, 0);
        check("arst_busy",  busy, 0);
        check("arst_irq",   irq, 0);
        tick(3);
        exp_q.delete();
        addr_q.delete();
        rst_n = 1'b1;
        tick(5);
        check("post_rst_req",  bus.rd_req, 0);
        check("post_rst_done", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/vertexinput_fetch_ctrl.md
Name: vertexinput_fetch_ctrl

Overview:
- Downstream consumer of the vertex-input register block. Takes the decoded config fields and start/abort pulses from the register adapter and fetches a run of vertex words over a simple req/ack read port.
- Buffers the fetched words in a small FIFO and streams them out on a valid/ready interface.
- Returns status levels and interrupt-set strobes to the register block's read-only and read-to-clear fields.

Parameters:
- ADDR_W, 32, read address width.
- DATA_W, 32, vertex word width.
- CNT_W, 16, vertex count width.
- FIFO_DEPTH, 4, output buffer entries; power of 2, at least 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous assert, active-low
- cfg_base_addr  in  ADDR_W  first vertex address
- cfg_vtx_count  in  CNT_W  number of vertices to fetch
- cfg_stride  in  8  byte increment between vertices
- start_pulse  in  1  single-cycle start strobe
- abort_pulse  in  1  single-cycle abort strobe
- status_busy  out  1  engine active
- status_done  out  1  last run completed normally
- irq_flags  out  2  sticky flags; bit0 = done, bit1 = zero-count error
- irq_clr  in  2  per-bit clear strobe for irq_flags
- rd_req  out  1  read request
- rd_addr  out  ADDR_W  read address
- rd_ack  in  1  read complete; rd_data valid this cycle
- rd_data  in  DATA_W  read data
- m_vtx_valid  out  1  output word valid
- m_vtx_data  out  DATA_W  output word
- m_vtx_last  out  1  marks the final word of a run
- m_vtx_ready  in  1  downstream accept

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, FIFO empty, internal counters 0.
- FSM states: IDLE, FETCH, DRAIN, ABORT.
- IDLE:
  - start_pulse with cfg_vtx_count != 0: latch base, count and stride; clear status_done; enter FETCH.
  - start_pulse with cfg_vtx_count == 0: set irq_flags[1]; remain in IDLE.
- FETCH:
  - Only one read outstanding at a time.
  - rd_req is asserted when (FIFO occupancy + 1) <= FIFO_DEPTH, counting the entry the pending read will fill.
  - First rd_req is asserted the cycle after start_pulse.
  - rd_req and rd_addr are held stable until rd_ack. rd_req deasserts in the cycle after the ack.
  - The next rd_req may assert in the cycle following that deassertion.
  - On rd_ack, rd_data is pushed into the FIFO. The push carries last = 1 for vertex index count-1.
- Address arithmetic:
  - rd_addr = base + idx * stride, computed incrementally by adding zero-extended stride.
  - Wraps modulo 2^ADDR_W with no error.
- FETCH to DRAIN: on the ack for the final index.
- DRAIN to IDLE:
  - Transition occurs when the FIFO is empty, i.e. the last word has been accepted.
  - On that transition: set status_done and irq_flags[0].
- ABORT:
  - abort_pulse in FETCH or DRAIN enters ABORT.
  - Any rd_req already asserted stays asserted until its rd_ack; the acked data is discarded.
  - The FIFO is flushed: m_vtx_valid drops the cycle after entry.
  - Return to IDLE once no request is outstanding.
  - No done flag and no status_done are set.
  - abort_pulse in IDLE is ignored.
- status_busy = (state != IDLE), registered.
- start_pulse while busy is ignored. Latched config is unaffected by later cfg changes.
- Output stream (FIFO):
  - First-word fall-through: m_vtx_valid/data/last reflect the FIFO head.
  - A pop occurs when m_vtx_valid & m_vtx_ready.
  - A simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
  - Data reaches m_vtx_valid one cycle after the rd_ack cycle.
  - Data is held stable while valid && !ready.
- irq_flags:
  - Each bit is sticky once set.
  - irq_clr[i] clears bit i.
  - A set event in the same cycle as the clear wins: bit stays 1.
- Asynchronous reset mid-run: everything returns to reset values immediately, including dropping rd_req. The read port owner must tolerate the dropped request.

Test Plan:
- Basic run: base=0x1000, count=3, stride=16, ready held 1.
  - rd_addr sequence is 0x1000, 0x1010, 0x1020.
  - 3 words output; m_vtx_last on the third only.
  - irq_flags=01, status_done=1, busy falls after the last pop.
- Backpressure, FIFO_DEPTH=4, count=8, ready held 0:
  - Exactly 4 rd_acks, then rd_req stays low.
  - Releasing ready completes all 8 words in order with no loss.
- Zero count: start with cfg_vtx_count=0.
  - irq_flags[1]=1, busy stays 0, no rd_req.
  - irq_clr=2'b10 clears it; a clear coinciding with a new zero-count start leaves it 1.
- Wrap-around: base=0xFFFF_FFF8, stride=8, count=3.
  - rd_addr sequence is 0xFFFF_FFF8, 0x0000_0000, 0x0000_0008.
- Abort with a request outstanding (rd_ack delayed 5 cycles):
  - rd_req held until ack; that word is not output; FIFO is flushed.
  - Returns to IDLE with irq_flags=00 and status_done=0.
  - A new start then works normally.
- Start while busy and reset mid-run:
  - A second start_pulse during FETCH does not change the address sequence.
  - aresetn low during FETCH immediately clears rd_req, m_vtx_valid and busy.
